dump_window_ctrl: RTL
=====================

DUMP_WINDOW_CTRL -- requirements
Module: dump_window_ctrl

Interface
REQ-001 SHALL have parameter START_COMMIT, default 0: zero-based commit index at which waveform dumping begins.
REQ-002 SHALL have parameter DUMP_LEN, default 0: commits dumped before the window closes; 0 means unbounded.
REQ-003 SHALL have parameter TIMEOUT, default 10000: consecutive cycles without a commit that raise timeout_err.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port commit_valid, input, 1: one instruction retires this cycle.
REQ-007 SHALL have port commit_order, input, 64: retirement sequence number of the committing instruction.
REQ-008 SHALL have port commit_insn, input, 32: encoding of the committing instruction.
REQ-009 SHALL have port commit_pc_rdata, input, 32: PC of the committing instruction.
REQ-010 SHALL have port commit_pc_wdata, input, 32: next PC after the committing instruction.
REQ-011 SHALL have port dump_on, output, 1: waveform dump enable, consumed by the top-level bench.
REQ-012 SHALL have port halt, output, 1: sticky; program reached the halt idiom.
REQ-013 SHALL have port timeout_err, output, 1: sticky; commit stall exceeded TIMEOUT.
REQ-014 SHALL have port order_err, output, 1: sticky; commit_order out of sequence.
REQ-015 SHALL have port commit_count, output, 64: number of commits accepted since reset.

Function
REQ-016 SHALL implement states IDLE, DUMPING and DONE; dump_on SHALL be 1 exactly when the state is DUMPING, and SHALL be driven from a register.
REQ-017 SHALL increment commit_count by 1 on every cycle with commit_valid=1, in all states, with natural 64-bit wrap.
REQ-018 SHALL compare commit_order with commit_count (pre-increment value) on each commit; on mismatch, SHALL set order_err the next cycle, and order_err SHALL remain set until reset.
REQ-019 SHALL, in IDLE, on a commit with commit_count==START_COMMIT, move to DUMPING the next cycle; that commit itself SHALL NOT be dumped.
REQ-020 SHALL keep a 64-bit dumped-commit counter, cleared on entry to DUMPING; when DUMP_LEN!=0 and the counter reaches DUMP_LEN, SHALL move to DONE the next cycle.
REQ-021 SHALL detect halt as a commit with commit_insn==32'h00000063 and commit_pc_rdata==commit_pc_wdata.
REQ-022 SHALL, on halt detection, set halt the next cycle (sticky) and move to DONE from any state.
REQ-023 SHALL keep a stall counter: cleared on each commit and incremented otherwise; it SHALL saturate at TIMEOUT.
REQ-024 SHALL, when the stall counter reaches TIMEOUT with no halt pending, set timeout_err (sticky) and move to DONE.
REQ-025 SHALL freeze the stall counter once halt=1, so that no timeout follows a halt.
REQ-026 SHALL make DONE terminal until reset, with no re-entry into DUMPING.
REQ-027 SHALL apply this priority for simultaneous events in one cycle: halt > timeout > DUMP_LEN close > START_COMMIT open; a halt on the START_COMMIT commit SHALL go IDLE->DONE with dump_on never asserted.
REQ-028 SHALL continue order checking and commit counting in DONE.

Reset
REQ-029 SHALL, while rst=1, immediately force: state=DUMPING if START_COMMIT==0, else IDLE; dump_on=(START_COMMIT==0); halt=0; timeout_err=0; order_err=0; commit_count=0; all internal counters 0.
REQ-030 SHALL, on rst asserted mid-window, drop dump_on asynchronously when START_COMMIT!=0, and discard all window progress.
REQ-031 SHALL begin counting on the first rising edge after rst deasserts.

Verification
REQ-032 Bench SHALL cover: START_COMMIT=5, DUMP_LEN=3, orders 0..9 one per cycle -> dump_on=1 in the cycles after commits 5 through 8, then 0 permanently; commit_count=10.
REQ-033 Bench SHALL cover: defaults, reset release -> dump_on=1 from reset; commit insn 0x00000063 with pc_rdata=pc_wdata=0x1eceb000 -> halt=1 and dump_on=0 the next cycle.
REQ-034 Bench SHALL cover: TIMEOUT=16, 3 commits then idle -> timeout_err=1 exactly 16 cycles after the last commit; halt stays 0.
REQ-035 Bench SHALL cover: commit orders 0,1,3 -> order_err=1 the cycle after order 3; commit_count=3.
REQ-036 Bench SHALL cover: START_COMMIT=2 with a halt commit at order 2 -> dump_on never asserts and halt=1; a later idle stall produces no timeout_err.
REQ-037 Bench SHALL cover: rst pulsed while in DUMPING with START_COMMIT=4 -> dump_on=0 during rst without a clock edge; all sticky flags and commit_count=0.

Source files
------------

// File: rtl/dump_window_ctrl.sv
// -----------------------------------------------------------------------------
// dump_window_ctrl
//
// Watches the retirement stream of a core under test and decides when the
// surrounding bench should record waveforms. A window opens after a chosen
// commit index, optionally closes after a fixed number of dumped commits, and
// is forced shut by a halt idiom or by a commit stall. Sticky error flags and a
// running commit count are exported for the bench to inspect.
//
// Parameters
//   START_COMMIT : zero-based commit index that opens the dump window
//   DUMP_LEN     : commits dumped before the window closes (0 = unbounded)
//   TIMEOUT      : consecutive commit-less cycles that raise timeout_err
//
// Ports
//   clk             in   sole clock, rising edge
//   rst             in   asynchronous, active-high reset
//   commit_valid    in   one instruction retires this cycle
//   commit_order    in   [63:0] retirement sequence number
//   commit_insn     in   [31:0] instruction encoding
//   commit_pc_rdata in   [31:0] PC of the retiring instruction
//   commit_pc_wdata in   [31:0] next PC after the retiring instruction
//   dump_on         out  waveform dump enable (registered)
//   halt            out  sticky, halt idiom retired
//   timeout_err     out  sticky, commit stall reached TIMEOUT
//   order_err       out  sticky, commit_order out of sequence
//   commit_count    out  [63:0] commits accepted since reset
// -----------------------------------------------------------------------------
module dump_window_ctrl #(
  parameter logic [63:0] START_COMMIT = 64'd0,
  parameter logic [63:0] DUMP_LEN     = 64'd0,
  parameter int unsigned TIMEOUT      = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [63:0] commit_order,
  input  logic [31:0] commit_insn,
  input  logic [31:0] commit_pc_rdata,
  input  logic [31:0] commit_pc_wdata,
  output logic        dump_on,
  output logic        halt,
  output logic        timeout_err,
  output logic        order_err,
  output logic [63:0] commit_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DUMPING = 2'd1,
    DONE    = 2'd2
  } state_t;

  // With START_COMMIT==0 the window is already open out of reset.
  localparam state_t      RST_STATE  = (START_COMMIT == 64'd0) ? DUMPING : IDLE;
  localparam logic        RST_DUMP   = (START_COMMIT == 64'd0);
  // "beq x0,x0,0": a branch to itself, the conventional end-of-test idiom.
  localparam logic [31:0] HALT_INSN  = 32'h0000_0063;
  localparam logic [31:0] STALL_LIM  = TIMEOUT;

  state_t      state;
  state_t      state_nxt;
  logic        dump_on_nxt;

  logic [63:0] dump_cnt;
  logic [31:0] stall;
  logic [31:0] stall_nxt;

  logic        halt_det;
  logic        order_bad;
  logic        timeout_hit;
  logic        len_hit;
  logic        start_hit;

  // ---------------------------------------------------------------------------
  // Event decode for the current cycle
  // ---------------------------------------------------------------------------
  assign halt_det  = commit_valid && (commit_insn == HALT_INSN) &&
                     (commit_pc_rdata == commit_pc_wdata);

  // The expected order is the pre-increment commit count.
  assign order_bad = commit_valid && (commit_order != commit_count);

  // Stall counter: frozen after halt, cleared by any commit, otherwise counts
  // up and saturates at the limit.
  always_comb begin
    stall_nxt = stall;
    if (!halt) begin
      if (commit_valid)
        stall_nxt = '0;
      else if (stall < STALL_LIM)
        stall_nxt = stall + 32'd1;
    end
  end

  // Fires on the edge at which the stall count reaches the limit. A commit in
  // the same cycle (including a halting one) always clears the stall, so it
  // can never coincide with a halt detection.
  assign timeout_hit = !halt && !commit_valid && (stall_nxt == STALL_LIM);

  // Window close uses the registered dump count, so the commit that brings the
  // count to DUMP_LEN is itself still inside the window.
  assign len_hit   = (DUMP_LEN != 64'd0) && (state == DUMPING) &&
                     (dump_cnt == DUMP_LEN);

  // The opening commit is seen while still IDLE and is therefore not dumped.
  assign start_hit = (state == IDLE) && commit_valid &&
                     (commit_count == START_COMMIT);

  // ---------------------------------------------------------------------------
  // FSM: state register (dump_on registered alongside the state)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RST_STATE;
      dump_on <= RST_DUMP;
    end else begin
      state   <= state_nxt;
      dump_on <= dump_on_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Priority halt > timeout > length close > open.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (halt_det || timeout_hit) begin
      state_nxt = DONE;
    end else begin
      case (state)
        IDLE:    if (start_hit) state_nxt = DUMPING;
        DUMPING: if (len_hit)   state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = DONE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode. Computed from the next state so the registered
  // dump_on tracks the state register exactly.
  // ---------------------------------------------------------------------------
  always_comb begin
    dump_on_nxt = (state_nxt == DUMPING);
  end

  // ---------------------------------------------------------------------------
  // Counters and sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_count <= '0;
      stall        <= '0;
      halt         <= 1'b0;
      timeout_err  <= 1'b0;
      order_err    <= 1'b0;
    end else begin
      if (commit_valid)
        commit_count <= commit_count + 64'd1;
      stall       <= stall_nxt;
      halt        <= halt | halt_det;
      timeout_err <= timeout_err | timeout_hit;
      order_err   <= order_err | order_bad;
    end
  end

  // Dumped-commit count: restarts on each entry into the window and counts
  // commits retired while the window is open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dump_cnt <= '0;
    end else if ((state != DUMPING) && (state_nxt == DUMPING)) begin
      dump_cnt <= '0;
    end else if ((state == DUMPING) && commit_valid) begin
      dump_cnt <= dump_cnt + 64'd1;
    end
  end

endmodule
